// File: rtl/fwseq_pkg.sv
// Shared definitions for the feature/weight select sequencer: FSM state
// encoding, per-phase select modes, default phase lengths and small helpers.
package fwseq_pkg;

  // Default phase lengths; these reproduce the legacy 25-step select table.
  localparam int DEF_PRE_LEN   = 4;
  localparam int DEF_LOAD_LEN  = 6;
  localparam int DEF_ILV_A_LEN = 6;
  localparam int DEF_ILV_B_LEN = 4;
  localparam int DEF_FLUSH_LEN = 5;
  localparam int DEF_CNT_W     = 5;

  // Sequencer FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ILV_A = 3'd3,
    ST_ILV_B = 3'd4,
    ST_FLUSH = 3'd5,
    ST_DONE  = 3'd6
  } fwseq_state_t;

  // How the select is derived within a phase.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,  // constant 0 (feature path)
    SEL_ONE  = 2'd1,  // constant 1 (weight path)
    SEL_ODD  = 2'd2,  // 1 on odd local counts
    SEL_EVEN = 2'd3   // 1 on even local counts
  } sel_mode_t;

  // Phase that follows a given phase once its local count terminates.
  function automatic fwseq_state_t fwseq_next_phase(input fwseq_state_t st);
    fwseq_state_t nxt;
    case (st)
      ST_PRE:   nxt = ST_LOAD;
      ST_LOAD:  nxt = ST_ILV_A;
      ST_ILV_A: nxt = ST_ILV_B;
      ST_ILV_B: nxt = ST_FLUSH;
      ST_FLUSH: nxt = ST_DONE;
      default:  nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

  // True for the states in which the sequence is running.
  function automatic logic fwseq_is_active(input fwseq_state_t st);
    return (st == ST_PRE) || (st == ST_LOAD) || (st == ST_ILV_A) ||
           (st == ST_ILV_B) || (st == ST_FLUSH);
  endfunction

  // Select mode used in each state; IDLE and DONE drive the feature path.
  function automatic sel_mode_t fwseq_sel_mode(input fwseq_state_t st);
    sel_mode_t m;
    case (st)
      ST_LOAD:  m = SEL_ONE;
      ST_ILV_A: m = SEL_ODD;
      ST_ILV_B: m = SEL_EVEN;
      ST_FLUSH: m = SEL_ONE;
      default:  m = SEL_ZERO;
    endcase
    return m;
  endfunction

  // Resolve a select mode against the local-count parity.
  function automatic logic fwseq_sel(input sel_mode_t m, input logic lsb);
    logic s;
    case (m)
      SEL_ONE:  s = 1'b1;
      SEL_ODD:  s = lsb;
      SEL_EVEN: s = ~lsb;
      default:  s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fwseq_phase_counter.sv
// Per-phase local counter shared by all phases. The phase length (minus one)
// is supplied by the caller, so one counter serves every phase. Exposes the
// terminal-count flag and the parity of the next count value, which is all
// the select logic needs.
module fwseq_phase_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,     // force the count to 0 on the next edge
  input  logic         adv,       // advance; wraps to 0 after the terminal count
  input  logic [W-1:0] len_m1,    // current phase length minus one
  output logic         tc,        // count has reached len_m1
  output logic         next_lsb   // bit 0 of the value the count takes next
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  // Next-count selection: clear dominates, then advance-with-wrap, else hold.
  always_comb begin
    tc         = (count_reg == len_m1);
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (adv) begin
      count_next = tc ? '0 : count_reg + 1'b1;
    end
    next_lsb = count_next[0];
  end

  // Local count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/feature_weight_sel_sequencer.sv
// Feature/weight select sequencer. Runs PRE -> LOAD -> ILV_A -> ILV_B ->
// FLUSH once per accepted start, emitting a global step count and the
// PE-array input mux select (0 = feature path, 1 = weight path), then pulses
// done for one cycle. All outputs are registered; the select is derived from
// the next state and next local count so it lines up with cnt.
// Optional build macro: FWSEQ_STALL_EN adds a stall input that freezes the
// running sequence.
module feature_weight_sel_sequencer
  import fwseq_pkg::*;
#(
  parameter int PRE_LEN   = DEF_PRE_LEN,
  parameter int LOAD_LEN  = DEF_LOAD_LEN,
  parameter int ILV_A_LEN = DEF_ILV_A_LEN,
  parameter int ILV_B_LEN = DEF_ILV_B_LEN,
  parameter int FLUSH_LEN = DEF_FLUSH_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
`ifdef FWSEQ_STALL_EN
  input  logic             stall,
`endif
  output logic [CNT_W-1:0] cnt,
  output logic             feature_weight_en_sel,
  output logic             active,
  output logic             done
);

  localparam int TOTAL = PRE_LEN + LOAD_LEN + ILV_A_LEN + ILV_B_LEN + FLUSH_LEN;
  localparam logic [4:0][31:0] LENS = {32'(FLUSH_LEN), 32'(ILV_B_LEN),
                                       32'(ILV_A_LEN), 32'(LOAD_LEN), 32'(PRE_LEN)};

  // Elaboration-time parameter sanity: every phase non-empty, cnt wide enough.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_len_chk
      if ($signed(LENS[gi]) < 1) begin : g_bad_len
        $error("feature_weight_sel_sequencer: phase length %0d must be >= 1", gi);
      end
    end
    if ((64'd1 << CNT_W) < 64'(TOTAL)) begin : g_bad_cnt_w
      $error("feature_weight_sel_sequencer: CNT_W too narrow for TOTAL steps");
    end
  endgenerate

  logic stall_int;
`ifdef FWSEQ_STALL_EN
  assign stall_int = stall;
`else
  assign stall_int = 1'b0;
`endif

  fwseq_state_t     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sel_reg, sel_next;
  logic             active_reg, active_next;
  logic             done_reg, done_next;

  logic             lcl_clear;
  logic             lcl_adv;
  logic             lcl_tc;
  logic             lcl_next_lsb;
  logic [CNT_W-1:0] len_m1;

  // Length of the phase currently running, fed to the shared local counter.
  always_comb begin
    len_m1 = '0;
    case (state_reg)
      ST_PRE:   len_m1 = CNT_W'(PRE_LEN - 1);
      ST_LOAD:  len_m1 = CNT_W'(LOAD_LEN - 1);
      ST_ILV_A: len_m1 = CNT_W'(ILV_A_LEN - 1);
      ST_ILV_B: len_m1 = CNT_W'(ILV_B_LEN - 1);
      ST_FLUSH: len_m1 = CNT_W'(FLUSH_LEN - 1);
      default:  len_m1 = '0;
    endcase
  end

  fwseq_phase_counter #(
    .W(CNT_W)
  ) u_phase_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (lcl_clear),
    .adv      (lcl_adv),
    .len_m1   (len_m1),
    .tc       (lcl_tc),
    .next_lsb (lcl_next_lsb)
  );

  // Next-state, global count and registered-output next values.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lcl_clear  = 1'b0;
    lcl_adv    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (start) begin
          state_next = ST_PRE;
          lcl_clear  = 1'b1;
        end
      end
      ST_PRE, ST_LOAD, ST_ILV_A, ST_ILV_B, ST_FLUSH: begin
        if (!stall_int) begin
          lcl_adv = 1'b1;
          if (lcl_tc) begin
            state_next = fwseq_next_phase(state_reg);
          end
          // The last FLUSH step leaves cnt at TOTAL-1 for the DONE cycle.
          if (!(state_reg == ST_FLUSH && lcl_tc)) begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        lcl_clear  = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        lcl_clear  = 1'b1;
      end
    endcase
    active_next = fwseq_is_active(state_next);
    done_next   = (state_next == ST_DONE);
    sel_next    = fwseq_sel(fwseq_sel_mode(state_next), lcl_next_lsb);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      sel_reg    <= 1'b0;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sel_reg    <= sel_next;
      active_reg <= active_next;
      done_reg   <= done_next;
    end
  end

  assign cnt                   = cnt_reg;
  assign feature_weight_en_sel = sel_reg;
  assign active                = active_reg;
  assign done                  = done_reg;

endmodule

// File: tb/tb_feature_weight_sel_sequencer.sv
// Testbench for feature_weight_sel_sequencer: a default-parameter instance
// and a short-phase instance share start/stall/reset_n. Each is compared
// every cycle with a position-based model (idle / step index / done).
module tb_feature_weight_sel_sequencer;

`ifdef FWSEQ_STALL_EN
  localparam bit HAS_STALL = 1'b1;
`else
  localparam bit HAS_STALL = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       stall;

  logic [4:0] cnt_a;
  logic       sel_a, active_a, done_a;
  logic [3:0] cnt_b;
  logic       sel_b, active_b, done_b;

  feature_weight_sel_sequencer dut_a (
    .clk                   (clk),
    .reset_n               (reset_n),
    .start                 (start),
`ifdef FWSEQ_STALL_EN
    .stall                 (stall),
`endif
    .cnt                   (cnt_a),
    .feature_weight_en_sel (sel_a),
    .active                (active_a),
    .done                  (done_a)
  );

  feature_weight_sel_sequencer #(
    .PRE_LEN(2), .LOAD_LEN(3), .ILV_A_LEN(1), .ILV_B_LEN(2), .FLUSH_LEN(1), .CNT_W(4)
  ) dut_b (
    .clk                   (clk),
    .reset_n               (reset_n),
    .start                 (start),
`ifdef FWSEQ_STALL_EN
    .stall                 (stall),
`endif
    .cnt                   (cnt_b),
    .feature_weight_en_sel (sel_b),
    .active                (active_b),
    .done                  (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pos = -1 idle, 0..total-1 running step, total = done cycle.
  int pos   [2];
  int total [2];
  bit tbl   [2][32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  // Build the cnt->sel table directly from the phase rules.
  task automatic build_table(input int d, input int l0, input int l1, input int l2,
                             input int l3, input int l4);
    int lens [5];
    int k;
    lens = '{l0, l1, l2, l3, l4};
    k = 0;
    for (int p = 0; p < 5; p++) begin
      for (int l = 0; l < lens[p]; l++) begin
        case (p)
          0: tbl[d][k] = 1'b0;
          1: tbl[d][k] = 1'b1;
          2: tbl[d][k] = (l % 2) == 1;
          3: tbl[d][k] = (l % 2) == 0;
          default: tbl[d][k] = 1'b1;
        endcase
        k++;
      end
    end
    total[d] = k;
    pos[d]   = -1;
  endtask

  task automatic check_outputs();
    logic [31:0] e_cnt;
    logic        e_sel, e_act, e_done;
    for (int d = 0; d < 2; d++) begin
      e_act  = (pos[d] >= 0) && (pos[d] < total[d]);
      e_done = (pos[d] == total[d]);
      e_cnt  = e_act ? pos[d] : (e_done ? total[d] - 1 : 0);
      e_sel  = e_act ? tbl[d][pos[d]] : 1'b0;
      if (d == 0) begin
        check("a_cnt", {27'd0, cnt_a}, e_cnt);
        check("a_sel", {31'd0, sel_a}, {31'd0, e_sel});
        check("a_active", {31'd0, active_a}, {31'd0, e_act});
        check("a_done", {31'd0, done_a}, {31'd0, e_done});
      end else begin
        check("b_cnt", {28'd0, cnt_b}, e_cnt);
        check("b_sel", {31'd0, sel_b}, {31'd0, e_sel});
        check("b_active", {31'd0, active_b}, {31'd0, e_act});
        check("b_done", {31'd0, done_b}, {31'd0, e_done});
      end
    end
  endtask

  // One clock: drive inputs just after a falling edge, advance the model,
  // then compare on the next falling edge.
  task automatic step(input bit st, input bit sl);
    bit sl_eff;
    sl_eff = sl & HAS_STALL;
    start  = st;
    stall  = sl_eff;
    for (int d = 0; d < 2; d++) begin
      if (pos[d] < 0) begin
        if (st) pos[d] = 0;
      end else if (pos[d] < total[d]) begin
        if (!sl_eff) pos[d] = pos[d] + 1;
      end else begin
        pos[d] = -1;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic async_reset();
    start   = 1'b0;
    stall   = 1'b0;
    reset_n = 1'b0;
    #1;
    pos[0] = -1;
    pos[1] = -1;
    check_outputs();
    #2;
    reset_n = 1'b1;
  endtask

  task automatic run_to(input int d, input int target);
    for (int i = 0; i < 40 && pos[d] != target; i++) step(1'b0, 1'b0);
    check("run_to_reached", pos[d], target);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    stall   = 1'b0;
    build_table(0, 4, 6, 6, 4, 5);
    build_table(1, 2, 3, 1, 2, 1);
    @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
    step(1'b0, 1'b0);

    // Single run, default and short tables.
    step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);

    // start held: back-to-back runs.
    repeat (60) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);

    // Reset in the middle of ILV_A, then a fresh run.
    step(1'b1, 1'b0);
    run_to(0, 12);
    async_reset();
    repeat (4) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);

    // Stall three cycles at cnt=15.
    step(1'b1, 1'b0);
    run_to(0, 15);
    repeat (3) step(1'b0, 1'b1);
    repeat (30) step(1'b0, 1'b0);

    // start while running and during DONE is ignored.
    step(1'b1, 1'b0);
    run_to(0, 7);
    step(1'b1, 1'b0);
    run_to(0, total[0]);
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
